// File: rtl/adc_pack_pkg.sv
`default_nettype none
// ============================================================================
// Package : adc_pack_pkg
// Brief   : Shared constants and types for the ADC frame packer.
//           ADC_FRAME_HEADER_EN selects the 9-word (header + 8 channel) frame.
// Rev     : 1.0  initial release
// ============================================================================
package adc_pack_pkg;

    localparam int NUM_CH = 8;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

`ifdef ADC_FRAME_HEADER_EN
    localparam int WORDS_PER_FRAME = NUM_CH + 1;
`else
    localparam int WORDS_PER_FRAME = NUM_CH;
`endif
    localparam int LAST_IDX = WORDS_PER_FRAME - 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Four bits cover the nine-word header build as well as the plain one.
    typedef logic [3:0] word_idx_t;

    // Element 0 holds channel 1.
    typedef logic [NUM_CH-1:0][15:0] frame_t;

endpackage
`default_nettype wire

// File: rtl/adc_frame_mux.sv
`default_nettype none
// ============================================================================
// Module : adc_frame_mux
// Brief  : Combinational word selector for the active frame slot.
//          ADC_FRAME_HEADER_EN places a {HDR_MAGIC, seq} word at index 0.
// Rev    : 1.0  initial release
// ============================================================================
module adc_frame_mux
    import adc_pack_pkg::*;
(
    input  logic [NUM_CH*16-1:0] i_active,
    input  logic [3:0]           i_idx,
`ifdef ADC_FRAME_HEADER_EN
    input  logic [7:0]           i_seq,
`endif
    output logic [15:0]          o_word,
    output logic                 o_last
);

    always_comb begin
        o_word = '0;
`ifdef ADC_FRAME_HEADER_EN
        if (i_idx == 4'd0) begin
            o_word = {HDR_MAGIC, i_seq};
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_idx == 4'(i + 1)) begin
                o_word = i_active[i*16 +: 16];
            end
        end
`else
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_idx == 4'(i)) begin
                o_word = i_active[i*16 +: 16];
            end
        end
`endif
    end

    assign o_last = (i_idx == 4'(LAST_IDX));

endmodule
`default_nettype wire

// File: rtl/adc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module : adc_frame_packer
// Brief  : Snapshots eight ADC channels per conversion and streams them as a
//          framed valid/ready burst through a two-slot buffer, counting drops.
//          ADC_FRAME_HEADER_EN prefixes each frame with a sequence header.
// Rev    : 1.0  initial release
// ============================================================================
module adc_frame_packer
    import adc_pack_pkg::*;
#(
    parameter int OVR_CNT_W = 8
)
(
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic [15:0]          adc_ch1_data_in,
    input  logic [15:0]          adc_ch2_data_in,
    input  logic [15:0]          adc_ch3_data_in,
    input  logic [15:0]          adc_ch4_data_in,
    input  logic [15:0]          adc_ch5_data_in,
    input  logic [15:0]          adc_ch6_data_in,
    input  logic [15:0]          adc_ch7_data_in,
    input  logic [15:0]          adc_ch8_data_in,
    input  logic                 adc_read_done,
    output logic [15:0]          m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic [OVR_CNT_W-1:0] overrun_cnt
);

    frame_t               r_pend;
    frame_t               r_active;
    logic                 r_pend_v;
    logic                 r_done_q;
    state_t               r_state;
    word_idx_t            r_idx;
    logic [OVR_CNT_W-1:0] r_ovr;
`ifdef ADC_FRAME_HEADER_EN
    logic [7:0]           r_seq;
`endif

    frame_t               w_in;
    logic                 w_cap;
    logic                 w_xfer;
    logic [15:0]          w_word;
    logic                 w_last;

    assign w_in   = {adc_ch8_data_in, adc_ch7_data_in, adc_ch6_data_in, adc_ch5_data_in,
                     adc_ch4_data_in, adc_ch3_data_in, adc_ch2_data_in, adc_ch1_data_in};
    assign w_cap  = adc_read_done & ~r_done_q;
    assign w_xfer = (r_state == ST_IDLE) & r_pend_v;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q <= 1'b0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_active <= '0;
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_ovr    <= '0;
`ifdef ADC_FRAME_HEADER_EN
            r_seq    <= '0;
`endif
        end else begin
            r_done_q <= adc_read_done;

            // The pending slot may be refilled in the same cycle it drains.
            if (w_cap && (!r_pend_v || w_xfer)) begin
                r_pend   <= w_in;
                r_pend_v <= 1'b1;
            end else begin
                if (w_cap && (r_ovr != '1)) begin
                    r_ovr <= r_ovr + 1'b1;
                end
                if (w_xfer) begin
                    r_pend_v <= 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend_v) begin
                        r_active <= r_pend;
                        r_idx    <= '0;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_ready) begin
                        if (r_idx == 4'(LAST_IDX)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
`ifdef ADC_FRAME_HEADER_EN
                        if (r_idx == 4'd0) begin
                            r_seq <= r_seq + 8'd1;
                        end
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    adc_frame_mux u_mux (
        .i_active (r_active),
        .i_idx    (r_idx),
`ifdef ADC_FRAME_HEADER_EN
        .i_seq    (r_seq),
`endif
        .o_word   (w_word),
        .o_last   (w_last)
    );

    assign m_valid     = (r_state == ST_SEND);
    assign m_data      = m_valid ? w_word : 16'd0;
    assign m_last      = m_valid & w_last;
    assign busy        = m_valid | r_pend_v;
    assign overrun_cnt = r_ovr;

endmodule
`default_nettype wire

// File: doc/adc_frame_packer.md
# adc_frame_packer

Downstream consumer of the AD7606 parallel capture wrapper: on each completed eight-channel conversion (`adc_read_done`), snapshots the eight 16-bit channel samples and streams them out as one framed burst on a valid/ready word interface. It sits between the ADC front-end and the packet/FIFO logic. It decouples the fixed conversion cadence from a back-pressuring consumer using a two-slot frame buffer and counts dropped frames.

## Interface
- `OVR_CNT_W`, default 8: width of the saturating overrun counter.
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `adc_ch1_data_in` … `adc_ch8_data_in`  in  16 each  channel samples from the capture wrapper; stable while `adc_read_done` is high.
- `adc_read_done`  in  1  frame-complete flag from the capture wrapper; level, possibly multi-cycle.
- `m_data`  out  16  stream word.
- `m_valid`  out  1  word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_last`  out  1  marks the final word of a frame.
- `busy`  out  1  high while in SEND or while the pending slot is full.
- `overrun_cnt`  out  OVR_CNT_W  dropped-frame count; saturates at all-ones.

## Operation
- Edge detect: register `adc_read_done` into `done_q`. `cap = adc_read_done & ~done_q`. Exactly one capture per done pulse, whatever the pulse length.
- Pending slot: 8×16 registers plus `pend_v`.
  - On `cap` with `pend_v==0`, or with `pend_v==1` while the FSM moves pending to active in the same cycle: write all eight inputs into pending and set `pend_v=1`.
  - On `cap` with `pend_v==1` and no transfer in that cycle: drop the new frame and increment `overrun_cnt` (saturating). The pending contents are unchanged.
- Active slot: 8×16 registers, plus word index `idx`.
- FSM states:
  - IDLE: if `pend_v`, copy pending to active, set `idx=0`, clear `pend_v` (unless a same-cycle `cap` refills it), go to SEND.
  - SEND: `m_valid=1`, `m_data=word[idx]`. On `m_valid & m_ready`: if `idx==LAST_IDX`, go to IDLE; otherwise increment `idx`.
- Word order: channel 1 first through channel 8 last. `m_last` is high only on the channel-8 word.
- `m_data`/`m_last` are forced to 0 when `m_valid==0`. While `m_valid & ~m_ready`, `m_data` and `m_last` are held stable. `m_valid` never drops without a handshake.

## Timing
- Reset values:
  - `m_valid=0`, `m_data=0`, `m_last=0`, `busy=0`, `overrun_cnt=0`.
  - `pend_v=0`, `done_q=0`, FSM=IDLE, `idx=0`, header sequence=0.
- Latency: `cap` sampled at edge k sets pending at edge k. The FSM enters SEND at edge k+1, so `m_valid` is high in the cycle after edge k+1: two cycles from the `adc_read_done` rise.
- Throughput: with `m_ready` held at 1, one word per cycle. There is exactly one IDLE bubble cycle between consecutive frames.
- Reset mid-frame discards the active and pending frames immediately. Streaming does not resume until a new `cap`.
- At 100 MHz / 20 kSPS (5000 cycles per frame), overrun occurs only under sustained back-pressure longer than about one frame period.

## Configuration
- `ADC_FRAME_HEADER_EN` defined:
  - Each frame is prefixed by a header word `{8'hA5, seq[7:0]}`, giving 9 words per frame and `LAST_IDX=8`.
  - `seq` increments when the header handshake completes and wraps 255→0.
  - Dropped frames do not consume a sequence number.
- Not defined: 8 words per frame, `LAST_IDX=7`, and no sequence logic is synthesised.

## Structure
- Package `adc_pack_pkg`: `NUM_CH=8`, `HDR_MAGIC=8'hA5`, FSM state typedef (`ST_IDLE`, `ST_SEND`), word-index typedef sized for 9 words.
- One sub-module is natural: `adc_frame_mux`, a combinational word selector. Inputs: active slot, `idx`, and `seq` (under the macro). Output: the selected word and its `last` flag.

## Test plan
- Single frame with channels = 0x1111…0x8888 and `m_ready=1`:
  - `m_valid` rises two cycles after the done rise.
  - Words appear in order 0x1111…0x8888 (header 0xA500 first when the macro is on).
  - `m_last` is asserted only on 0x8888.
- Back-pressure: hold `m_ready=0` for 10 cycles mid-frame. `m_data`, `m_last` and `m_valid` must stay stable; the stream resumes with no lost or repeated word.
- Overrun: hold `m_ready=0` and send three done pulses. Frame 1 goes to active, frame 2 to pending, frame 3 is dropped, giving `overrun_cnt=1`. Release `m_ready`: frames 1 and 2 stream, separated by one bubble cycle.
- Long `adc_read_done` (50 cycles high): exactly one frame is captured and emitted.
- Assert `rst_n=0` at word 4 of a frame: all outputs return to 0 immediately. After release, no words are output until the next done.
- Macro on, 257 frames: header `seq` wraps 0xFF→0x00. Saturation check with `OVR_CNT_W=2`: five drops leave `overrun_cnt=3`.
